// File: rtl/subtractor_seq_n_if.sv
// ----------------------------------------------------------------------------
// subtractor_seq_n_if
//   Request/response bundle between a controlling FSM (master) and the
//   chunk-serial subtractor (slave).
//
//   start : request pulse, sampled only while the subtractor is idle
//   A, B  : minuend / subtrahend, N*WORDS bits, sampled on the accept edge
//   Bin   : borrow-in, sampled on the accept edge
//   busy  : high while an operation is in flight (RUN or DONE)
//   done  : one-cycle pulse, DIFF/Bout are final
//   DIFF  : difference modulo 2^(N*WORDS)
//   Bout  : borrow-out of the most significant chunk
// ----------------------------------------------------------------------------
interface subtractor_seq_n_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    logic                 start;
    logic [N*WORDS-1:0]   A;
    logic [N*WORDS-1:0]   B;
    logic                 Bin;
    logic                 busy;
    logic                 done;
    logic [N*WORDS-1:0]   DIFF;
    logic                 Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, DIFF, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, DIFF, Bout
    );
endinterface

// File: rtl/subtractor_seq_n.sv
// ----------------------------------------------------------------------------
// subtractor_seq_n
//   Multi-cycle subtractor: DIFF = A - B - Bin over N*WORDS-bit operands,
//   one N-bit chunk per clock, least significant chunk first. The borrow
//   between chunks lives in a register so a single narrow N-bit stage serves
//   the whole operand width.
//
//   Ports:
//     clk : clock, all state changes on the rising edge
//     rst : asynchronous, active-high reset
//     bus : subtractor_seq_n_if.slave (start/A/B/Bin in, busy/done/DIFF/Bout out)
//
//   Timing (accept edge at t):
//     chunk edges t+1 .. t+WORDS, done high in the cycle after edge t+WORDS,
//     back to IDLE at edge t+WORDS+1, next accept at t+WORDS+2 at the earliest.
// ----------------------------------------------------------------------------
module subtractor_seq_n #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    subtractor_seq_n_if.slave  bus
);

    localparam int              IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IDXW-1:0]         idx_q;
    logic                    borrow_q;
    // Operands and result are held chunk-addressable so the running index
    // selects a whole N-bit chunk directly.
    logic [WORDS-1:0][N-1:0] a_q;
    logic [WORDS-1:0][N-1:0] b_q;
    logic [WORDS-1:0][N-1:0] diff_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    bout_q;

    // One chunk step in N+1 bits: the top bit is set exactly when
    // a - b - borrow is negative, i.e. it is the borrow into the next chunk.
    logic [N:0]              step_d;

    always_comb begin
        step_d = {1'b0, a_q[idx_q]} - {1'b0, b_q[idx_q]} - {{N{1'b0}}, borrow_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        borrow_q <= bus.Bin;
                        idx_q    <= '0;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    diff_q[idx_q] <= step_d[N-1:0];
                    borrow_q      <= step_d[N];
                    if (idx_q == LAST) begin
                        bout_q  <= step_d[N];
                        // Parked at 0 so the index never leaves 0..WORDS-1.
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.DIFF = diff_q;
    assign bus.Bout = bout_q;

endmodule

// File: tb/tb_subtractor_seq_n.sv
// ----------------------------------------------------------------------------
// tb_subtractor_seq_n
//   Directed bench: an N=4/WORDS=2 instance for the vector table and the
//   multi-cycle corner sequences, and an N=3/WORDS=2 instance for a full
//   operand sweep.
// ----------------------------------------------------------------------------
module tb_subtractor_seq_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    subtractor_seq_n_if #(.N(4), .WORDS(2)) bus4 ();
    subtractor_seq_n_if #(.N(3), .WORDS(2)) bus3 ();

    subtractor_seq_n #(.N(4), .WORDS(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    subtractor_seq_n #(.N(3), .WORDS(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One full operation on the 8-bit instance. Inputs are scrambled right
    // after the accept edge; only the latched copies may matter.
    task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] diff, output logic bout,
                       output int busy_n, output int done_n,
                       output logic [7:0] held_diff, output logic held_bout,
                       output logic idle_seen);
        busy_n = 0; done_n = 0; diff = '0; bout = 1'b0;
        held_diff = '0; held_bout = 1'b0; idle_seen = 1'b0;
        @(negedge clk);
        bus4.A = a; bus4.B = b; bus4.Bin = bin; bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0; bus4.A = ~a; bus4.B = ~b; bus4.Bin = ~bin;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus4.busy) busy_n++;
            if (bus4.done) begin
                done_n++;
                diff = bus4.DIFF;
                bout = bus4.Bout;
            end
            if (!bus4.busy) begin
                held_diff = bus4.DIFF;
                held_bout = bus4.Bout;
                idle_seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic op3(input logic [5:0] a, input logic [5:0] b, input logic bin,
                       output logic [6:0] res, output int done_n, output logic idle_seen);
        res = '0; done_n = 0; idle_seen = 1'b0;
        @(negedge clk);
        bus3.A = a; bus3.B = b; bus3.Bin = bin; bus3.start = 1'b1;
        @(posedge clk);
        #1;
        bus3.start = 1'b0; bus3.A = ~a; bus3.B = ~b;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus3.done) begin
                done_n++;
                res = {bus3.Bout, bus3.DIFF};
            end
            if (!bus3.busy) begin
                idle_seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] d, hd;
        logic       bo, hb, idle;
        int         bn, dn;
        logic [6:0] busy_pat, done_pat;
        logic [6:0] res3, exp3;

        vecs[0] = '{a: 8'h53, b: 8'h21, bin: 1'b0, diff: 8'h32, bout: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h01, bin: 1'b0, diff: 8'h0F, bout: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h01, bin: 1'b0, diff: 8'hFF, bout: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, diff: 8'hFF, bout: 1'b1};
        vecs[4] = '{a: 8'h80, b: 8'h7F, bin: 1'b0, diff: 8'h01, bout: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1};
        vecs[6] = '{a: 8'hA5, b: 8'h5A, bin: 1'b1, diff: 8'h4A, bout: 1'b0};
        vecs[7] = '{a: 8'h0F, b: 8'h0F, bin: 1'b0, diff: 8'h00, bout: 1'b0};

        rst = 1'b1;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Bin = 1'b0;
        bus3.start = 1'b0; bus3.A = '0; bus3.B = '0; bus3.Bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", bus4.busy, 1'b0);
        chk("reset done", bus4.done, 1'b0);
        chk("reset DIFF", bus4.DIFF, 8'h00);
        chk("reset Bout", bus4.Bout, 1'b0);
        chk("reset n3 outputs", {bus3.busy, bus3.done, bus3.Bout, bus3.DIFF}, 9'h000);
        rst = 1'b0;

        // Vector table
        for (int v = 0; v < 8; v++) begin
            op4(vecs[v].a, vecs[v].b, vecs[v].bin, d, bo, bn, dn, hd, hb, idle);
            chk($sformatf("vec%0d DIFF", v), d, vecs[v].diff);
            chk($sformatf("vec%0d Bout", v), bo, vecs[v].bout);
            chk($sformatf("vec%0d busy cycles", v), bn, 3);
            chk($sformatf("vec%0d done pulses", v), dn, 1);
            chk($sformatf("vec%0d held result", v), {idle, hb, hd}, {1'b1, vecs[v].bout, vecs[v].diff});
        end

        // start held high across a whole operation; inputs change during RUN
        busy_pat = 7'b1110111;
        done_pat = 7'b1000100;
        @(negedge clk);
        bus4.A = 8'h53; bus4.B = 8'h21; bus4.Bin = 1'b0; bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.A = 8'h00; bus4.B = 8'h00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("held-start busy c%0d", i), bus4.busy, busy_pat[i]);
            chk($sformatf("held-start done c%0d", i), bus4.done, done_pat[i]);
            if (i == 2) chk("held-start first result", {bus4.Bout, bus4.DIFF}, 9'h032);
            if (i == 4) begin
                chk("held-start DIFF cleared on accept", bus4.DIFF, 8'h00);
                bus4.start = 1'b0;
            end
            if (i == 6) chk("held-start second result", {bus4.Bout, bus4.DIFF}, 9'h000);
        end
        @(negedge clk);
        chk("held-start idle after", bus4.busy, 1'b0);

        // Reset during the second RUN cycle aborts without a done pulse
        bus4.A = 8'h53; bus4.B = 8'h21; bus4.Bin = 1'b0; bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort pre busy", bus4.busy, 1'b1);
        chk("abort pre partial DIFF", bus4.DIFF, 8'h02);
        #1 rst = 1'b1;
        #1;
        chk("abort async clear", {bus4.busy, bus4.done, bus4.Bout, bus4.DIFF}, 11'h000);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus4.done) dn++;
        end
        chk("abort no done pulse", dn, 0);
        op4(8'h21, 8'h53, 1'b0, d, bo, bn, dn, hd, hb, idle);
        chk("post-abort DIFF", d, 8'hCE);
        chk("post-abort Bout", bo, 1'b1);
        chk("post-abort done pulses", dn, 1);

        // Full sweep on the 6-bit instance
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op3(6'(a), 6'(b), 1'(c), res3, dn, idle);
                    exp3 = 7'((a - b - c) & 127);
                    chk($sformatf("sweep a=%0d b=%0d bin=%0d {idle,done,Bout,DIFF}", a, b, c),
                        {idle, 2'(dn), res3}, {1'b1, 2'd1, exp3});
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/subtractor_seq_n.md
Name: subtractor_seq_n

Overview:
- Multi-cycle, chunk-serial subtractor: computes A - B - Bin over N*WORDS-bit operands, one N-bit chunk per clock, LSB chunk first.
- Borrow is held in a register and chained between chunks.
- This is the subtraction counterpart to the team's combinational N-bit adder chain. It is intended for datapaths where wide operands must share one narrow N-bit stage.
- Start/busy/done handshake toward a controlling FSM.

Parameters:
- N, 8, chunk width in bits (one chunk subtracted per cycle).
- WORDS, 4, number of chunks; operand width is N*WORDS. WORDS >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  N*WORDS  minuend; sampled on the accepting edge.
- B  input  N*WORDS  subtrahend; sampled on the accepting edge.
- Bin  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse: result valid.
- DIFF  output  N*WORDS  difference, modulo 2^(N*WORDS).
- Bout  output  1  borrow-out from the MSB chunk.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, chunk index=0, borrow register=0.
  - busy=0, done=0, DIFF=0, Bout=0.
  - Operand registers are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on an edge with start=1.
  - RUN -> RUN while idx < WORDS-1.
  - RUN -> DONE on the edge that processes idx = WORDS-1.
  - DONE -> IDLE unconditionally after one cycle.
- Accept edge (IDLE, start=1):
  - Latch A and B internally; borrow <= Bin; idx <= 0.
  - DIFF <= 0, Bout <= 0.
  - busy goes high after this edge.
- Each RUN edge:
  - Compute {b, d} = A[idx] - B[idx] - borrow, using (N+1)-bit unsigned arithmetic on the N-bit chunks; b=1 iff the true result is negative.
  - DIFF[idx*N +: N] <= d; borrow <= b; idx <= idx+1.
  - On the last chunk, Bout <= b in addition.
- DONE: done=1 for exactly one cycle; busy still 1. DIFF and Bout are final.
- Latency: accept edge at t; chunk edges at t+1 .. t+WORDS; done high during the cycle after edge t+WORDS. The next start can be accepted at edge t+WORDS+2 at the earliest.
- Result identity: A - B - Bin = DIFF - Bout*2^(N*WORDS).
- DIFF and Bout hold their final values after DONE until the next accept.
- start while busy (RUN or DONE): ignored. No queuing, no effect on the current operation.
- A, B and Bin may change freely after the accept edge; only the latched copies are used.
- Reset asserted mid-RUN or in DONE: immediate abort to reset values. No done pulse is produced for the aborted operation.
- WORDS=1: a single RUN edge, then DONE.

Test Plan:
- N=4, WORDS=2: A=0x53, B=0x21, Bin=0, start pulse -> after 2 RUN cycles done pulses once; DIFF=0x32, Bout=0; busy=1 for exactly 3 cycles.
- N=4, WORDS=2: A=0x10, B=0x01, Bin=0 -> borrow chains from chunk 0 into chunk 1; DIFF=0x0F, Bout=0.
- N=4, WORDS=2: A=0x00, B=0x01, Bin=0 -> DIFF=0xFF, Bout=1. Then A=0xFF, B=0xFF, Bin=1 -> DIFF=0xFF, Bout=1.
- Start held high continuously with A=0x53, B=0x21; inputs changed to A=0x00, B=0x00 during RUN:
  - First result is 0x32.
  - No second accept before IDLE.
  - Next accept occurs at edge t+4, giving DIFF=0x00, Bout=0.
- Assert rst during the second RUN cycle -> busy, done, DIFF and Bout go to 0 immediately (asynchronously) with no done pulse. A following start with A=0x21, B=0x53 gives DIFF=0xCE, Bout=1.
- Exhaustive sweep, N=3, WORDS=2: all A, B in 0..63 and Bin in 0..1 -> {Bout,DIFF} matches the integer reference (A - B - Bin) mod 128 in 7 bits; done pulses exactly once per operation.
